avs_pio_gen2: RTL and testbench

//  Parametrised Avalon-MM slave PIO; successor to the fixed LED/button/dipsw/pio_N PIO instances in soc_system.

---
 rtl/avs_pio_pkg.sv | 17 +
 rtl/pio_debounce.sv | 60 ++++++
 rtl/avs_pio_gen2.sv | 139 +++++++++++++
 tb/tb_avs_pio_gen2.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/avs_pio_pkg.sv
// Shared constants for the Avalon-MM PIO block: register word offsets and
// edge-capture mode encodings.
package avs_pio_pkg;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGECAP = 3'd3;
    localparam logic [2:0] REG_OUTSET  = 3'd4;
    localparam logic [2:0] REG_OUTCLR  = 3'd5;

    localparam int EDGE_NONE = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;
    localparam int EDGE_ANY  = 3;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit debouncer. The output follows the synchronised input only after
// the input has differed from the accepted value for DEBOUNCE_CYC cycles.
// DEBOUNCE_CYC = 0 degenerates to a single register stage.
module pio_debounce #(
    parameter int DEBOUNCE_CYC = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic db_o
);

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            logic db_q;

            // Bypass: accepted value is the synchronised input, one cycle later
            always_ff @(posedge clk) begin
                if (reset) db_q <= 1'b0;
                else       db_q <= sync_i;
            end

            assign db_o = db_q;
        end else begin : g_count
            localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          db_q, db_d;

            // Count mismatching cycles; accept on reaching the limit, where the
            // counter holds (no wrap) until the input matches again
            always_comb begin
                cnt_d = cnt_q;
                db_d  = db_q;
                if (sync_i == db_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    db_d = sync_i;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Counter and accepted-value registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    db_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    db_q  <= db_d;
                end
            end

            assign db_o = db_q;
        end
    endgenerate

endmodule

// File: rtl/avs_pio_gen2.sv
// Parametrised Avalon-MM slave PIO: per-bit direction, synchronised and
// debounced inputs, sticky edge capture and a maskable registered IRQ.
//
// Bus handshake: no waitrequest. avs_write commits at the clock edge it is
// sampled on. avs_read is sampled at an edge and avs_readdata carries the
// answer from that edge onward (fixed latency 1), holding until the next read.
// A read and a write in the same cycle return the pre-write register value.
module avs_pio_gen2
    import avs_pio_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               SYNC_STAGES  = 2,
    parameter int               DEBOUNCE_CYC = 0,
    parameter int               EDGE_MODE    = 3,
    parameter logic [WIDTH-1:0] DIR_RESET    = '0,
    parameter logic [WIDTH-1:0] OUT_RESET    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_db, prev_q;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] edge_hit, cap_set, wd;
    logic [31:0]      readdata_q, readdata_d, rd_val;
    logic             irq_q, irq_d;
    logic             unused_wd;

    assign wd        = avs_writedata[WIDTH-1:0];
    assign unused_wd = ^avs_writedata;

    // Input synchroniser chain for the asynchronous pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_db
            pio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
                .clk    (clk),
                .reset  (reset),
                .sync_i (sync_q[SYNC_STAGES-1][g]),
                .db_o   (in_db[g])
            );
        end
    endgenerate

    // Edge selection on debounced input; only input-direction bits capture
    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            EDGE_RISE: edge_hit = in_db & ~prev_q;
            EDGE_FALL: edge_hit = ~in_db & prev_q;
            EDGE_ANY:  edge_hit = in_db ^ prev_q;
            default:   edge_hit = '0;
        endcase
        cap_set = edge_hit & ~dir_q;
    end

    // Register-file writes; a new capture overrides a same-cycle W1C
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        edgecap_d  = edgecap_q;
        if (avs_write) begin
            case (avs_address)
                REG_DATA:    data_out_d = wd;
                REG_DIR:     dir_d      = wd;
                REG_IRQMASK: mask_d     = wd;
                REG_EDGECAP: edgecap_d  = edgecap_q & ~wd;
                REG_OUTSET:  data_out_d = data_out_q | wd;
                REG_OUTCLR:  data_out_d = data_out_q & ~wd;
                default:     ;
            endcase
        end
        edgecap_d = edgecap_d | cap_set;
        irq_d     = |(edgecap_q & mask_q);
    end

    // Read mux from pre-write register state; readdata holds between reads
    always_comb begin
        rd_val = '0;
        case (avs_address)
            REG_DATA:    rd_val[WIDTH-1:0] = (dir_q & data_out_q) | (~dir_q & in_db);
            REG_DIR:     rd_val[WIDTH-1:0] = dir_q;
            REG_IRQMASK: rd_val[WIDTH-1:0] = mask_q;
            REG_EDGECAP: rd_val[WIDTH-1:0] = edgecap_q;
            default:     rd_val = '0;
        endcase
        readdata_d = avs_read ? rd_val : readdata_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= OUT_RESET;
            dir_q      <= DIR_RESET;
            mask_q     <= '0;
            edgecap_q  <= '0;
            prev_q     <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            prev_q     <= in_db;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign pio_out      = data_out_q;
    assign pio_oe       = dir_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_avs_pio_gen2.sv
// Directed bench for avs_pio_gen2 (16 bits, 2 sync stages, 4-cycle debounce,
// rising-edge capture). Reads push their expected word into a queue; a
// monitor pops and compares when the read data becomes valid.
module tb_avs_pio_gen2;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic [W-1:0]  pio_in = '0;
  logic [W-1:0]  pio_out;
  logic [W-1:0]  pio_oe;
  logic          irq;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q[$];
  string         name_q[$];
  logic          rd_vld = 1'b0;

  avs_pio_gen2 #(
    .WIDTH        (W),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (4),
    .EDGE_MODE    (1),
    .DIR_RESET    (16'h00FF),
    .OUT_RESET    (16'h00A5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .pio_in        (pio_in),
    .pio_out       (pio_out),
    .pio_oe        (pio_oe),
    .irq           (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // read data is valid the cycle after the read strobe is sampled
  always @(posedge clk) rd_vld <= avs_read;

  // scoreboard monitor
  logic [31:0] mon_exp;
  string       mon_name;
  always @(negedge clk) begin
    if (rd_vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got %h, no expected value queued", avs_readdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (avs_readdata !== mon_exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", mon_name, avs_readdata, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    step(1);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    avs_address = a;
    avs_read    = 1'b1;
    step(1);
    avs_read    = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    avs_address   = a;
    avs_writedata = d;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    step(1);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // reset values
    step(3);
    check("rst_pio_out", 32'(pio_out), 32'h00A5);
    check("rst_pio_oe", 32'(pio_oe), 32'h00FF);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    reset = 1'b0;
    rd(3'd0, 32'h0000_00A5, "rst_data");
    rd(3'd1, 32'h0000_00FF, "rst_dir");
    rd(3'd2, 32'h0, "rst_mask");
    rd(3'd3, 32'h0, "rst_edgecap");

    // output set/clear and unused addresses
    wr(3'd0, 32'h0000_00F0);
    check("data_write", 32'(pio_out), 32'h00F0);
    wr(3'd4, 32'h0000_000F);
    wr(3'd5, 32'h0000_0030);
    check("set_clr", 32'(pio_out), 32'h00CF);
    rd(3'd4, 32'h0, "outset_rd");
    rd(3'd5, 32'h0, "outclr_rd");
    rd(3'd6, 32'h0, "addr6_rd");
    rd(3'd7, 32'h0, "addr7_rd");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0, 32'h0000_00CF, "data_after_addr6_wr");

    // upper write bits ignored, read-during-write returns old value
    wr(3'd2, 32'hFFFF_0009);
    rd(3'd2, 32'h0000_0009, "mask_upper_bits");
    rdwr(3'd1, 32'h0000_0F0F, 32'h0000_00FF, "rd_wr_same_cycle");
    rd(3'd1, 32'h0000_0F0F, "dir_after_rdwr");
    wr(3'd1, 32'h0);
    check("dir_all_in", 32'(pio_oe), 32'h0);
    check("out_retained", 32'(pio_out), 32'h00CF);

    // debounce latency on pin0: reads sampled 1..7 edges after the pin change
    pio_in[0] = 1'b1;
    for (int i = 0; i < 7; i++) rd(3'd0, (i == 6) ? 32'h1 : 32'h0, "db_latency");
    check("irq_pre_capture", 32'(irq), 32'h0);
    step(1);
    check("irq_pin0", 32'(irq), 32'h1);
    rd(3'd3, 32'h1, "edgecap_pin0");

    // 3-cycle glitch on pin1 is rejected; 4-cycle pulse on pin2 is accepted
    pio_in[1] = 1'b1;
    step(3);
    pio_in[1] = 1'b0;
    step(10);
    rd(3'd0, 32'h1, "glitch_rejected");
    pio_in[2] = 1'b1;
    step(4);
    pio_in[2] = 1'b0;
    step(10);
    rd(3'd3, 32'h5, "pulse4_captured");
    wr(3'd3, 32'h4);
    check("irq_mask_bit0", 32'(irq), 32'h1);

    // W1C of bit0 drops irq one cycle later
    wr(3'd3, 32'h1);
    check("irq_w1c_lag", 32'(irq), 32'h1);
    step(1);
    check("irq_w1c_clear", 32'(irq), 32'h0);
    rd(3'd3, 32'h0, "edgecap_cleared");

    // pin3 rising capture
    pio_in[3] = 1'b1;
    step(7);
    check("irq_pin3_pre", 32'(irq), 32'h0);
    rd(3'd3, 32'h8, "edgecap_pin3");
    check("irq_pin3", 32'(irq), 32'h1);
    wr(3'd3, 32'h8);
    step(1);
    check("irq_pin3_clear", 32'(irq), 32'h0);
    rd(3'd3, 32'h0, "edgecap_pin3_clear");

    // falling edge is not captured in rising mode
    pio_in[3] = 1'b0;
    step(10);
    rd(3'd3, 32'h0, "fall_ignored");
    check("irq_fall", 32'(irq), 32'h0);

    // W1C collides with a new capture on the same bit: set wins
    pio_in[3] = 1'b1;
    step(8);
    rd(3'd3, 32'h8, "edgecap_first_rise");
    pio_in[3] = 1'b0;
    step(10);
    pio_in[3] = 1'b1;
    step(6);
    wr(3'd3, 32'h8);
    check("collide_irq0", 32'(irq), 32'h1);
    step(1);
    check("collide_irq1", 32'(irq), 32'h1);
    rd(3'd3, 32'h8, "collide_edgecap");

    // reset while irq is asserted
    reset = 1'b1;
    step(1);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_oe", 32'(pio_oe), 32'h00FF);
    check("mid_rst_out", 32'(pio_out), 32'h00A5);
    check("mid_rst_readdata", avs_readdata, 32'h0);
    reset = 1'b0;
    rd(3'd3, 32'h0, "mid_rst_edgecap");
    rd(3'd1, 32'h0000_00FF, "mid_rst_dir");
    rd(3'd2, 32'h0, "mid_rst_mask");

    step(3);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
